// File: rtl/cube_frame_sequencer_pkg.sv
// Shared constants and types for the LED cube frame sequencer.
// Imported by the interface, frame RAM and sequencer top.
package cube_pkg;

    localparam int CUBE_DIM   = 8;
    localparam int BANK_DEPTH = CUBE_DIM * CUBE_DIM;

    typedef logic [5:0] frame_addr_t;
    typedef logic [2:0] layer_idx_t;
    typedef logic [2:0] row_idx_t;

    localparam row_idx_t   ROW_LAST   = 3'd7;
    localparam layer_idx_t LAYER_LAST = 3'd7;

    // IDLE wait enable | ISSUE start latch | WAIT_DONE await latcher | BLANK guard | DWELL layer lit
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        BLANK,
        DWELL
    } seq_state_t;

    function automatic logic [CUBE_DIM-1:0] layer_onehot(input layer_idx_t layer);
        return {{(CUBE_DIM-1){1'b0}}, 1'b1} << layer;
    endfunction

endpackage

// File: rtl/cube_frame_sequencer_if.sv
// Handshake between the frame sequencer (master) and the downstream row latcher (slave).
interface cube_frame_sequencer_if;
    import cube_pkg::*;

    logic       latch_start;
    row_idx_t   latch_idx;
    logic [7:0] latch_data;
    logic       latch_done;

    modport master (
        output latch_start,
        output latch_idx,
        output latch_data,
        input  latch_done
    );

    modport slave (
        input  latch_start,
        input  latch_idx,
        input  latch_data,
        output latch_done
    );

endinterface

// File: rtl/cube_frame_sequencer_ram.sv
// Frame storage: one write port and one synchronous, read-enabled read port.
// A same-edge read of the written address returns the previous contents.
module cube_frame_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Only the read register is reset; the array contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cube_frame_sequencer.sv
// Scans an 8x8x8 LED cube: latches 8 rows per layer, blanks, then lights the layer.
// Optional FRAME_DOUBLE_BUFFER_EN adds a back bank with frame-synchronous swap.
module cube_frame_sequencer
    import cube_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    wr_en,
    input  frame_addr_t             wr_addr,
    input  logic [7:0]              wr_data,
`ifdef FRAME_DOUBLE_BUFFER_EN
    input  logic                    swap_req,
    output logic                    swap_ack,
`endif
    cube_frame_sequencer_if.master  lat,
    output logic [CUBE_DIM-1:0]     layer_en,
    output logic                    frame_done
);

    localparam logic [15:0] DWELL_TC = 16'(DWELL_CYCLES - 1);
    localparam logic [15:0] BLANK_TC = 16'(BLANK_CYCLES - 1);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    layer_idx_t  r_layer;
    layer_idx_t  w_layer_nxt;
    row_idx_t    r_row;
    row_idx_t    w_row_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    row_idx_t    r_latch_idx;
    logic        w_rd_en;
    logic        w_dwell_end;
    logic [7:0]  w_rd_data;
    frame_addr_t w_rd_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_layer     <= '0;
            r_row       <= '0;
            r_cnt       <= '0;
            r_latch_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_layer <= w_layer_nxt;
            r_row   <= w_row_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_rd_en) begin
                r_latch_idx <= w_row_nxt;
            end
        end
    end

    // The RAM read is launched on the transition into ISSUE so that index and
    // data are registered and valid during the ISSUE cycle itself.
    always_comb begin
        w_state_nxt = r_state;
        w_layer_nxt = r_layer;
        w_row_nxt   = r_row;
        w_cnt_nxt   = r_cnt;
        w_rd_en     = 1'b0;
        w_dwell_end = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = ISSUE;
                    w_rd_en     = 1'b1;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (lat.latch_done) begin
                    if (r_row != ROW_LAST) begin
                        w_row_nxt   = r_row + 3'd1;
                        w_state_nxt = ISSUE;
                        w_rd_en     = 1'b1;
                    end else begin
                        w_state_nxt = BLANK;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            BLANK: begin
                if (r_cnt == BLANK_TC) begin
                    w_state_nxt = DWELL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            DWELL: begin
                if (r_cnt == DWELL_TC) begin
                    w_dwell_end = 1'b1;
                    w_cnt_nxt   = '0;
                    w_row_nxt   = '0;
                    w_layer_nxt = r_layer + 3'd1;
                    if (enable) begin
                        w_state_nxt = ISSUE;
                        w_rd_en     = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_rd_addr       = {w_layer_nxt, w_row_nxt};
    assign lat.latch_start = (r_state == ISSUE);
    assign lat.latch_idx   = r_latch_idx;
    assign lat.latch_data  = w_rd_data;
    assign layer_en        = (r_state == DWELL) ? layer_onehot(r_layer) : '0;
    assign frame_done      = w_dwell_end && (r_layer == LAYER_LAST);

`ifdef FRAME_DOUBLE_BUFFER_EN
    logic r_front;
    logic r_swap_pend;
    logic w_swap;
    logic w_front_nxt;

    // The read for the first row of the next frame happens on the swap edge,
    // so it must already address the new front bank.
    assign w_swap      = r_swap_pend && (frame_done || (r_state == IDLE));
    assign w_front_nxt = r_front ^ w_swap;
    assign swap_ack    = w_swap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_front     <= 1'b0;
            r_swap_pend <= 1'b0;
        end else begin
            r_front     <= w_front_nxt;
            r_swap_pend <= swap_req | (r_swap_pend & ~w_swap);
        end
    end

    cube_frame_ram #(
        .DEPTH (2 * BANK_DEPTH)
    ) u_frame_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_addr ({~r_front, wr_addr}),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr ({w_front_nxt, w_rd_addr}),
        .o_rd_data (w_rd_data)
    );
`else
    cube_frame_ram #(
        .DEPTH (BANK_DEPTH)
    ) u_frame_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );
`endif

endmodule
